// File: rtl/lsu_subword_ctrl_if.sv
// Word-wide data-memory bus with a ready/ack handshake.
// The LSU drives the request side (master); the memory answers (slave).
interface lsu_subword_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_subword_ctrl.sv
// Load/store sequencer for a word-only memory: lane-extracting loads and
// read-modify-write sub-word stores, stalling the core while a sequence runs.
module lsu_subword_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  input  logic              sext,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              stall,
  lsu_subword_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic [1:0]        off_q, off_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              legal;
  logic [3:0]        lm;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [3:0] size, input logic sx);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (size)
      4'b0001: extract = sx ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
      4'b0011: extract = sx ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
      default: extract = s;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input logic [1:0] off, input logic [3:0] lanes);
    logic [31:0] bm;
    for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{lanes[i]}};
    merge = (word & ~bm) | ((data << {off, 3'b000}) & bm);
  endfunction

  assign legal = (be == 4'b0001) ||
                 (be == 4'b0011 && !addr[0]) ||
                 (be == 4'b1111 && addr[1:0] == 2'b00);
  assign lm    = be_q << off_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    done_d      = 1'b0;
    we_d        = we_q;
    sext_d      = sext_q;
    off_d       = off_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d       = we;
          sext_d     = sext;
          off_d      = addr[1:0];
          be_d       = be;
          wdata_d    = wdata;
          mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
          if (!legal) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = RESP;
          end else if (we && be == 4'b1111) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = wdata;
            state_d     = WR;
          end else begin
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
            state_d   = RD;
          end
        end
      end
      RD: begin
        if (mem.mem_ack) begin
          if (!we_q) begin
            rdata_d   = extract(mem.mem_rdata, off_q, be_q, sext_q);
            err_d     = 1'b0;
            done_d    = 1'b1;
            mem_req_d = 1'b0;
            state_d   = RESP;
          end else begin
            // Read half of the read-modify-write: request stays up into WR.
            mem_wdata_d = merge(mem.mem_rdata, wdata_q, off_q, lm);
            mem_we_d    = 1'b1;
            state_d     = WR;
          end
        end
      end
      WR: begin
        if (mem.mem_ack) begin
          err_d     = 1'b0;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  // Captured request fields; only meaningful once a sequence has started.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    sext_q  <= sext_d;
    off_q   <= off_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
  end

  assign rdata         = rdata_q;
  assign done          = done_q;
  assign err           = err_q;
  assign stall         = reset & req & ~done_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Bench for lsu_subword_ctrl: wait-state memory responder, arithmetic reference
// model of loads/stores/latency, and a per-cycle compare process.
module tb_lsu_subword_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sext;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        done, err, stall;

  lsu_subword_ctrl_if #(.ADDR_W(32)) mem_if ();

  lsu_subword_ctrl #(.ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .be    (be),
    .sext  (sext),
    .rdata (rdata),
    .done  (done),
    .err   (err),
    .stall (stall),
    .mem   (mem_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pc = 0;
  always @(posedge clk) pc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model, expressed in bytes and integer arithmetic.
  function automatic int size_of(input logic [3:0] b);
    case (b)
      4'b0001: size_of = 1;
      4'b0011: size_of = 2;
      4'b1111: size_of = 4;
      default: size_of = 0;
    endcase
  endfunction

  function automatic bit legal_m(input logic [3:0] b, input logic [31:0] a);
    int n;
    n = size_of(b);
    legal_m = (n != 0) && ((a % n) == 0);
  endfunction

  function automatic logic [31:0] load_m(input logic [31:0] word, input logic [31:0] a,
                                         input logic [3:0] b, input logic sx);
    int n;
    longint unsigned v;
    n = size_of(b);
    v = {32'b0, word} >> (8 * (a % 4));
    if (n < 4) begin
      v = v & ((64'd1 << (8 * n)) - 64'd1);
      if (sx && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    end
    load_m = v[31:0];
  endfunction

  function automatic logic [31:0] store_m(input logic [31:0] word, input logic [31:0] a,
                                          input logic [31:0] wd, input logic [3:0] b);
    int n, off;
    logic [31:0] r;
    n = size_of(b);
    off = a % 4;
    r = word;
    for (int i = 0; i < n; i++) r[8 * (off + i) +: 8] = wd[8 * i +: 8];
    store_m = r;
  endfunction

  function automatic int lat_m(input logic wv, input logic [3:0] b, input logic [31:0] a,
                               input int wr, input int ww);
    if (!legal_m(b, a))   lat_m = 1;
    else if (!wv)         lat_m = 2 + wr;
    else if (b == 4'hF)   lat_m = 2 + ww;
    else                  lat_m = 3 + wr + ww;
  endfunction

  // Memory responder: ack after a configurable number of wait cycles.
  logic [31:0] memarr [64];
  int w_rd = 0, w_wr = 0, acnt = 0;
  always @(negedge clk) begin
    if (mem_if.mem_req) begin
      if (acnt >= (mem_if.mem_we ? w_wr : w_rd)) begin
        mem_if.mem_ack = 1'b1;
        acnt = 0;
        if (mem_if.mem_we) memarr[mem_if.mem_addr[7:2]] = mem_if.mem_wdata;
      end else begin
        mem_if.mem_ack = 1'b0;
        acnt++;
      end
    end else begin
      mem_if.mem_ack = 1'b0;
      acnt = 0;
    end
    mem_if.mem_rdata = memarr[mem_if.mem_addr[7:2]];
  end

  // Current transaction as seen by the compare process.
  bit          active = 0;
  int          start_pc, cur_lat, cur_wrd, ck;
  bit          cur_legal;
  logic        cur_we;
  logic [31:0] cur_addr, cur_word, exp_rdata;
  logic [3:0]  cur_be;

  always @(negedge clk) begin
    if (active) begin
      ck = pc - start_pc;
      chk("done", 32'(done), 32'(ck == cur_lat));
      chk("stall", 32'(stall), 32'(req && ck != cur_lat));
      chk("mem_req", 32'(mem_if.mem_req), 32'(cur_legal && ck >= 1 && ck < cur_lat));
      if (mem_if.mem_req) begin
        chk("mem_addr", mem_if.mem_addr, {cur_addr[31:2], 2'b00});
        chk("mem_we", 32'(mem_if.mem_we),
            32'(cur_we && (cur_be == 4'hF || ck >= 2 + cur_wrd)));
        if (mem_if.mem_we) chk("mem_wdata", mem_if.mem_wdata, cur_word);
      end
      if (ck == cur_lat) chk("err", 32'(err), 32'(!cur_legal));
      if (ck >= cur_lat) chk("rdata", rdata, exp_rdata);
    end
  end

  task automatic do_access(input logic wv, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] b, input logic sx, input int wr, input int ww,
                           input logic [31:0] init, output int kobs);
    memarr[a[7:2]] = init;
    w_rd      = wr;
    w_wr      = ww;
    cur_we    = wv;
    cur_addr  = a;
    cur_be    = b;
    cur_wrd   = wr;
    cur_legal = legal_m(b, a);
    cur_lat   = lat_m(wv, b, a, wr, ww);
    cur_word  = store_m(init, a, wd, b);
    if (cur_legal && !wv) exp_rdata = load_m(init, a, b, sx);
    @(posedge clk);
    #1;
    start_pc = pc;
    we = wv; addr = a; wdata = wd; be = b; sext = sx; req = 1'b1;
    active = 1;
    kobs = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        kobs = pc - start_pc;
        break;
      end
    end
    chk("done_seen", 32'(kobs >= 0), 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    #1 active = 0;
    chk("mem_word", memarr[a[7:2]], (cur_legal && wv) ? store_m(init, a, wd, b) : init);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int k;
  initial begin
    for (int i = 0; i < 64; i++) memarr[i] = 32'h0;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rdata = 32'h0;
    exp_rdata = 32'h0;
    reset = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; sext = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    chk("model_lb", load_m(32'h8899AABB, 32'h103, 4'h1, 1'b0), 32'h00000088);
    chk("model_lsb", load_m(32'h8899AABB, 32'h103, 4'h1, 1'b1), 32'hFFFFFF88);
    chk("model_lsh", load_m(32'h7FFF1234, 32'h102, 4'h3, 1'b1), 32'h00007FFF);
    chk("model_strb", store_m(32'h11223344, 32'h101, 32'hCC, 4'h1), 32'h1122CC44);
    chk("model_lat_strh", 32'(lat_m(1'b1, 4'h3, 32'h100, 2, 2)), 32'd7);

    do_access(1'b0, 32'h103, 32'h0, 4'h1, 1'b0, 0, 0, 32'h8899AABB, k);
    chk("lb_rdata", rdata, 32'h00000088);
    chk("lb_done_cyc", 32'(k), 32'd2);
    do_access(1'b0, 32'h103, 32'h0, 4'h1, 1'b1, 0, 0, 32'h8899AABB, k);
    chk("lsb_rdata", rdata, 32'hFFFFFF88);
    do_access(1'b0, 32'h102, 32'h0, 4'h3, 1'b1, 0, 0, 32'h7FFF1234, k);
    chk("lsh_rdata", rdata, 32'h00007FFF);
    do_access(1'b1, 32'h101, 32'hCC, 4'h1, 1'b0, 0, 0, 32'h11223344, k);
    chk("strb_word", memarr[0], 32'h1122CC44);
    chk("strb_done_cyc", 32'(k), 32'd3);
    chk("strb_rdata_kept", rdata, 32'h00007FFF);
    do_access(1'b1, 32'h100, 32'hBEEF, 4'h3, 1'b0, 2, 2, 32'hAAAAAAAA, k);
    chk("strh_word", memarr[0], 32'hAAAABEEF);
    chk("strh_done_cyc", 32'(k), 32'd7);
    do_access(1'b0, 32'h102, 32'h0, 4'hF, 1'b0, 0, 0, 32'h01020304, k);
    chk("ill_word_err", 32'(err), 32'd1);
    chk("ill_word_cyc", 32'(k), 32'd1);
    do_access(1'b0, 32'h101, 32'h0, 4'h3, 1'b1, 0, 0, 32'h01020304, k);
    chk("ill_half_err", 32'(err), 32'd1);
    do_access(1'b0, 32'h100, 32'h0, 4'h7, 1'b0, 0, 0, 32'h01020304, k);
    chk("ill_be7_err", 32'(err), 32'd1);
    do_access(1'b1, 32'h103, 32'h1234, 4'h3, 1'b0, 0, 0, 32'h0F0F0F0F, k);
    do_access(1'b0, 32'h104, 32'h0, 4'hF, 1'b1, 1, 0, 32'h12345678, k);
    chk("lw_rdata", rdata, 32'h12345678);
    chk("lw_err_clear", 32'(err), 32'd0);
    do_access(1'b1, 32'h108, 32'hDEADBEEF, 4'hF, 1'b0, 0, 3, 32'h0, k);
    chk("sw_word", memarr[2], 32'hDEADBEEF);
    do_access(1'b0, 32'h100, 32'h0, 4'h3, 1'b1, 0, 0, 32'h00008001, k);
    chk("lsh_neg", rdata, 32'hFFFF8001);
    do_access(1'b0, 32'h100, 32'h0, 4'h1, 1'b1, 1, 0, 32'h0000007F, k);
    chk("lsb_pos", rdata, 32'h0000007F);
    do_access(1'b1, 32'h103, 32'hFFFFFF5A, 4'h1, 1'b0, 1, 1, 32'h00000000, k);
    chk("strb_hi", memarr[0], 32'h5A000000);
    do_access(1'b1, 32'h102, 32'h12345678, 4'h3, 1'b0, 0, 0, 32'h11111111, k);
    chk("strh_hi", memarr[0], 32'h56781111);

    // Reset while a word store waits in WR.
    memarr[3] = 32'h55555555;
    w_rd = 0;
    w_wr = 5;
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h10C; wdata = 32'hCAFEF00D; be = 4'hF; sext = 1'b0; req = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_mem_req", 32'(mem_if.mem_req), 32'd1);
    chk("pre_rst_mem_we", 32'(mem_if.mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_req", 32'(mem_if.mem_req), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    req = 1'b0;
    exp_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("arst_no_write", memarr[3], 32'h55555555);
    #2 reset = 1'b1;
    do_access(1'b1, 32'h10C, 32'h0BADF00D, 4'hF, 1'b0, 0, 0, 32'h55555555, k);
    chk("post_rst_done_cyc", 32'(k), 32'd2);
    chk("post_rst_word", memarr[3], 32'h0BADF00D);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
